// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage feeding the decoder. Owns the program counter,
// issues word reads to instruction memory on a request/grant bus whose
// responses come back in issue order, and buffers returned words in a small
// prefetch FIFO. The FIFO head is offered to decode as {inst, inst_pc} with a
// valid/ready handshake. A jump_flag pulse flushes everything buffered,
// drops responses still in flight, and restarts fetch at jump_target.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   jump_flag    single-cycle redirect request
//   jump_target  redirect PC; bits [1:0] are ignored
//   imem_req     fetch request (held until granted)
//   imem_addr    word-aligned fetch address
//   imem_gnt     request accepted when imem_req && imem_gnt
//   imem_rvalid  response valid (in order, >= 1 cycle after grant)
//   imem_rdata   returned instruction word
//   inst_valid   FIFO head valid
//   inst         head instruction, 0 when !inst_valid
//   inst_pc      head PC, 0 when !inst_valid
//   inst_ready   decode accepts head when inst_valid && inst_ready
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    // Pointer width and a counter width that can hold 0..DEPTH inclusive.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t         fifo [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  discard;
    logic [31:0]    fetch_pc;
    logic [31:0]    resp_pc;

    logic           pop;
    logic           grant;
    logic           resp;
    logic           push;
    logic [CW:0]    credit;
    logic [31:0]    jump_pc;

    // Low target bits are dropped by design; keep lint quiet about them.
    logic unused_jump_lsbs;
    assign unused_jump_lsbs = &{1'b0, jump_target[1:0]};

    assign jump_pc    = {jump_target[31:2], 2'b00};
    assign inst_valid = (count != '0);

    // A pop in the redirect cycle is meaningless: the whole FIFO is flushed.
    assign pop = inst_valid && inst_ready && !jump_flag;

    // Credit check: every granted word already owns a FIFO slot, so the
    // FIFO cannot overflow. The pop term lets a slot freed this cycle be
    // reused immediately, which is what keeps DEPTH=2 at full rate.
    assign credit   = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
    assign imem_req = !rst && !jump_flag && (credit < (CW+1)'(DEPTH));

    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error; it is ignored
    // so the counters never underflow.
    assign resp = imem_rvalid && (outstanding != '0);

    // Stale responses (discard > 0) are dropped; anything arriving in the
    // redirect cycle would be flushed anyway, so it is not written.
    assign push = resp && (discard == '0) && !jump_flag;

    // Outputs are forced to zero when the head is empty so decode never sees
    // leftover words from flushed entries.
    assign inst    = inst_valid ? fifo[rd_ptr].word : 32'h0;
    assign inst_pc = inst_valid ? fifo[rd_ptr].pc   : 32'h0;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            // Grants and responses are counted in both branches; grant is
            // impossible during a redirect because imem_req is forced low.
            outstanding <= outstanding + CW'(grant) - CW'(resp);

            if (jump_flag) begin
                fetch_pc <= jump_pc;
                resp_pc  <= jump_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Everything still in flight after this cycle belongs to the
                // old path and must be dropped when it returns.
                discard  <= outstanding - CW'(resp);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage: payload only, no reset needed since count gates reads.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{word: imem_rdata, pc: resp_pc};
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Two instances: g_dut[0] (DEPTH=2, 1-cycle memory) carries streaming,
// backpressure, redirect table, grant stall and async reset; g_dut[1]
// (DEPTH=4, 3-cycle memory) carries the redirect-with-in-flight-reads case.
// Each instance has a memory model returning addr ^ 32'hA5A5_0000 and a
// scoreboard filled on every grant and drained on every accepted pop.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } want_t;

    typedef struct {
        int          due;
        logic [31:0] a;
    } pend_t;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    logic        jf  [2];
    logic [31:0] jt  [2];
    logic        gnt [2];
    logic        rdy [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D   = (g == 0) ? 2 : 4;
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        req;
        logic [31:0] addr;
        logic        rv = 1'b0;
        logic [31:0] rdat = 32'h0;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;

        pend_t       pend [$];
        want_t       sb   [$];
        int          mcyc = 0;
        logic [31:0] exp_fa = 32'h0;

        inst_fetch #(.RESET_PC(32'h0), .DEPTH(D)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .jump_flag   (jf[g]),
            .jump_target (jt[g]),
            .imem_req    (req),
            .imem_addr   (addr),
            .imem_gnt    (gnt[g]),
            .imem_rvalid (rv),
            .imem_rdata  (rdat),
            .inst_valid  (iv),
            .inst        (ins),
            .inst_pc     (ipc),
            .inst_ready  (rdy[g])
        );

        // Memory: a grant in cycle N returns in cycle N+LAT, in order.
        always @(posedge clk) begin
            mcyc <= mcyc + 1;
            if (rst) pend.delete();
            if (pend.size() > 0 && pend[0].due == mcyc + 1) begin
                rv   <= 1'b1;
                rdat <= pend[0].a ^ 32'hA5A5_0000;
                void'(pend.pop_front());
            end else begin
                rv   <= 1'b0;
                rdat <= 32'hDEAD_BEEF;
            end
        end

        // Scoreboard and fetch-address model, sampled mid-cycle.
        always @(negedge clk) begin
            if (rst) begin
                sb.delete();
                exp_fa <= 32'h0;
            end else begin
                if (!iv) begin
                    chk($sformatf("idle_inst%0d", g), ins, 32'h0);
                    chk($sformatf("idle_pc%0d", g), ipc, 32'h0);
                end
                if (iv && rdy[g] && !jf[g]) begin
                    chk($sformatf("sb_nonempty%0d", g), 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        chk($sformatf("sb_word%0d", g), ins, sb[0].word);
                        chk($sformatf("sb_pc%0d", g), ipc, sb[0].pc);
                        void'(sb.pop_front());
                    end
                end
                if (jf[g]) begin
                    sb.delete();
                    exp_fa <= {jt[g][31:2], 2'b00};
                end else if (req && gnt[g]) begin
                    chk($sformatf("fetch_addr%0d", g), addr, exp_fa);
                    sb.push_back('{word: exp_fa ^ 32'hA5A5_0000, pc: exp_fa});
                    pend.push_back('{due: mcyc + LAT, a: addr});
                    exp_fa <= exp_fa + 32'd4;
                end
                chk($sformatf("occupancy%0d", g), 32'(sb.size() <= D), 32'd1);
            end
        end
    end

    initial begin
        vec_t vt [4];
        logic req_low;

        vt[0] = '{tgt: 32'h0000_0100, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
        vt[1] = '{tgt: 32'h0000_0103, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
        vt[2] = '{tgt: 32'hFFFF_FFFC, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
        vt[3] = '{tgt: 32'h0000_2002, pc0: 32'h0000_2000, pc1: 32'h0000_2004};

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            jf[g]  = 1'b0;
            jt[g]  = 32'h0;
            rdy[g] = 1'b1;
        end
        gnt[0] = 1'b1;
        gnt[1] = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_req",   g_dut[0].req, 32'd0);
        chk("rst_valid", g_dut[0].iv,  32'd0);
        chk("rst_inst",  g_dut[0].ins, 32'h0);
        chk("rst_pc",    g_dut[0].ipc, 32'h0);
        chk("rst_req_b", g_dut[1].req, 32'd0);

        // Release and stream: first valid two cycles after release, then
        // valid every cycle.
        rst = 1'b0;
        #1;
        chk("c0_req",  g_dut[0].req,  32'd1);
        chk("c0_addr", g_dut[0].addr, 32'h0);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("stream_valid_c%0d", c), g_dut[0].iv, 32'(c >= 2));
            step();
        end

        // Backpressure
        rdy[0]  = 1'b0;
        req_low = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (!g_dut[0].req) req_low = 1'b1;
            chk("bp_hold_valid", g_dut[0].iv, 32'd1);
        end
        chk("bp_req_dropped", req_low, 32'd1);
        rdy[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("bp_flow_valid", g_dut[0].iv, 32'd1);
        end

        // Redirect table (1-cycle memory)
        for (int i = 0; i < 4; i++) begin
            jf[0] = 1'b1;
            jt[0] = vt[i].tgt;
            #1;
            chk($sformatf("jmp%0d_req_low", i), g_dut[0].req, 32'd0);
            step();
            jf[0] = 1'b0;
            #1;
            chk($sformatf("jmp%0d_j1_valid", i), g_dut[0].iv, 32'd0);
            chk($sformatf("jmp%0d_j1_req", i), g_dut[0].req, 32'd1);
            chk($sformatf("jmp%0d_j1_addr", i), g_dut[0].addr, vt[i].pc0);
            step();
            chk($sformatf("jmp%0d_j2_valid", i), g_dut[0].iv, 32'd0);
            chk($sformatf("jmp%0d_j2_addr", i), g_dut[0].addr, vt[i].pc1);
            step();
            chk($sformatf("jmp%0d_j3_valid", i), g_dut[0].iv, 32'd1);
            chk($sformatf("jmp%0d_j3_pc", i), g_dut[0].ipc, vt[i].pc0);
            chk($sformatf("jmp%0d_j3_inst", i), g_dut[0].ins, vt[i].pc0 ^ 32'hA5A5_0000);
            step();
            chk($sformatf("jmp%0d_j4_pc", i), g_dut[0].ipc, vt[i].pc1);
            repeat (3) step();
        end

        // Grant stall at address 8 (redirect to 0 first)
        jf[0] = 1'b1;
        jt[0] = 32'h0;
        step();
        jf[0] = 1'b0;
        step();
        step();
        gnt[0] = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("stall_addr", g_dut[0].addr, 32'h8);
            chk("stall_req",  g_dut[0].req,  32'd1);
            step();
        end
        gnt[0] = 1'b1;
        repeat (6) step();

        // Async reset with the FIFO full
        rdy[0] = 1'b0;
        repeat (4) step();
        chk("full_valid", g_dut[0].iv,  32'd1);
        chk("full_req",   g_dut[0].req, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", g_dut[0].iv,  32'd0);
        chk("arst_req",   g_dut[0].req, 32'd0);
        chk("arst_inst",  g_dut[0].ins, 32'h0);
        step();
        step();
        rst    = 1'b0;
        rdy[0] = 1'b1;
        #1;
        chk("rel_req",  g_dut[0].req,  32'd1);
        chk("rel_addr", g_dut[0].addr, 32'h0);
        repeat (4) step();
        chk("rel_valid", g_dut[0].iv, 32'd1);

        // Redirect with two reads in flight (DEPTH=4, 3-cycle memory)
        gnt[1] = 1'b1;
        step();
        step();
        gnt[1] = 1'b0;
        jf[1]  = 1'b1;
        jt[1]  = 32'h100;
        #1;
        chk("b_jmp_req_low", g_dut[1].req, 32'd0);
        step();
        jf[1]  = 1'b0;
        gnt[1] = 1'b1;
        #1;
        chk("b_j1_req",  g_dut[1].req,  32'd1);
        chk("b_j1_addr", g_dut[1].addr, 32'h100);
        for (int c = 3; c <= 6; c++) begin
            chk($sformatf("b_stale_drop_c%0d", c), g_dut[1].iv, 32'd0);
            step();
        end
        chk("b_first_valid", g_dut[1].iv,  32'd1);
        chk("b_first_pc",    g_dut[1].ipc, 32'h100);
        chk("b_first_inst",  g_dut[1].ins, 32'h100 ^ 32'hA5A5_0000);
        step();
        chk("b_second_pc",   g_dut[1].ipc, 32'h104);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
